// File: rtl/imm_gen_pipe_if.sv
// Handshake and data bundle for imm_gen_pipe: upstream instruction/selector/tag
// offer, downstream extended immediate, plus the occupancy count.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) ();
  logic [31:0]      i_inst;
  logic [2:0]       i_sel;   // cotm32_pkg::imm_t encoding
  logic [TAG_W-1:0] i_tag;
  logic             i_valid;
  logic             o_ready;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_imm;
  logic [TAG_W-1:0] o_tag;
  logic [2:0]       o_count;

  // Producer/consumer side (drives the inputs, observes the outputs)
  modport master (
    output i_inst, i_sel, i_tag, i_valid, i_flush, i_ready,
    input  o_ready, o_valid, o_imm, o_tag, o_count
  );

  // Pipeline side
  modport slave (
    input  i_inst, i_sel, i_tag, i_valid, i_flush, i_ready,
    output o_ready, o_valid, o_imm, o_tag, o_count
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator followed by a bubble-collapsing register pipeline.
// Decode is combinational; each stage carries valid/imm/tag and advances when it
// is empty or everything downstream of it can move.
package cotm32_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_Z = 3'd5
  } imm_t;
endpackage

module imm_gen_pipe
  import cotm32_pkg::*;
#(
  parameter int unsigned XLEN    = 32,   // 32 or 64
  parameter int unsigned STAGES  = 1,    // 1..4
  parameter int unsigned TAG_W   = 5,
  parameter bit          EN_ZIMM = 1'b1
) (
  input logic          i_clk,
  input logic          i_rst,
  imm_gen_pipe_if.slave pipe_io
);

  logic [31:0]     inst;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_dec;
  logic            unused_inst;

  assign inst        = pipe_io.i_inst;
  assign unused_inst = ^inst[6:0];  // opcode bits carry no immediate

  // Format decode to a 32-bit value whose bit 31 is the sign for every format
  always_comb begin
    imm32 = '0;
    case (pipe_io.i_sel)
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_Z:   imm32 = EN_ZIMM ? {27'b0, inst[19:15]} : 32'b0;
      default: imm32 = '0;
    endcase
  end

  // Widening to 64 bits replicates bit 31 (zimm has bit 31 clear, so stays zero-extended)
  assign imm_dec = XLEN'($signed(imm32));

  // Chain index 0 is the upstream offer, index k+1 is the output of stage k.
  logic [STAGES:0]  vld_c;
  logic [XLEN-1:0]  imm_c [STAGES+1];
  logic [TAG_W-1:0] tag_c [STAGES+1];
  logic [STAGES-1:0] adv;

  assign vld_c[0] = pipe_io.i_valid;
  assign imm_c[0] = imm_dec;
  assign tag_c[0] = pipe_io.i_tag;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    // A stage moves if it or any stage after it is empty, or the consumer takes data
    assign adv[k] = ~(&vld_c[STAGES:k+1]) | pipe_io.i_ready;

    // Load from upstream on advance, hold otherwise; flush kills valid regardless
    always_comb begin
      valid_d = valid_q;
      imm_d   = imm_q;
      tag_d   = tag_q;
      if (adv[k]) begin
        valid_d = vld_c[k];
        imm_d   = imm_c[k];
        tag_d   = tag_c[k];
      end
      if (pipe_io.i_flush) begin
        valid_d = 1'b0;
      end
    end

    // Stage registers with asynchronous clear
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        valid_q <= 1'b0;
        imm_q   <= '0;
        tag_q   <= '0;
      end else begin
        valid_q <= valid_d;
        imm_q   <= imm_d;
        tag_q   <= tag_d;
      end
    end

    assign vld_c[k+1] = valid_q;
    assign imm_c[k+1] = imm_q;
    assign tag_c[k+1] = tag_q;
  end

  assign pipe_io.o_ready = adv[0];
  assign pipe_io.o_valid = vld_c[STAGES];
  assign pipe_io.o_imm   = imm_c[STAGES];
  assign pipe_io.o_tag   = tag_c[STAGES];
  assign pipe_io.o_count = 3'($countones(vld_c[STAGES:1]));

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: two instances (32-bit/2-stage/zimm on, 64-bit/3-stage/
// zimm off) driven in lockstep, a per-cycle reference model, a vector table and
// directed sequences for stall, flush and asynchronous reset.
module tb_imm_gen_pipe;
  import cotm32_pkg::*;

  localparam int unsigned TW = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst;
  logic [2:0]  sel;
  logic [TW-1:0] tag;
  logic        valid, flush, ready;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(TW)) bus_a ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(TW)) bus_b ();

  assign bus_a.i_inst = inst;  assign bus_b.i_inst = inst;
  assign bus_a.i_sel = sel;    assign bus_b.i_sel = sel;
  assign bus_a.i_tag = tag;    assign bus_b.i_tag = tag;
  assign bus_a.i_valid = valid; assign bus_b.i_valid = valid;
  assign bus_a.i_flush = flush; assign bus_b.i_flush = flush;
  assign bus_a.i_ready = ready; assign bus_b.i_ready = ready;

  imm_gen_pipe #(.XLEN(32), .STAGES(2), .TAG_W(TW), .EN_ZIMM(1'b1)) u_a (
    .i_clk(clk), .i_rst(rst), .pipe_io(bus_a)
  );
  imm_gen_pipe #(.XLEN(64), .STAGES(3), .TAG_W(TW), .EN_ZIMM(1'b0)) u_b (
    .i_clk(clk), .i_rst(rst), .pipe_io(bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Immediate value from the ISA field definitions, as a 64-bit signed number
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] s,
                                          input bit en_z);
    longint sx, r;
    sx = longint'($signed(w));
    case (s)
      IMM_I:   r = sx >>> 20;
      IMM_S:   r = (sx >>> 25) * 32 + longint'(w[11:7]);
      IMM_B:   r = (sx >>> 31) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                   + longint'(w[11:8]) * 2;
      IMM_U:   r = (sx >>> 12) * 4096;
      IMM_J:   r = (sx >>> 31) * 1048576 + longint'(w[19:12]) * 4096
                   + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
      IMM_Z:   r = en_z ? longint'(w[19:15]) : 64'sd0;
      default: r = 0;
    endcase
    return r;
  endfunction

  // Reference model: ordered list of in-flight entries with their stage position
  typedef struct {
    logic [63:0]   imm;
    logic [TW-1:0] tag;
    int            pos;
  } ent_t;

  ent_t mq [2][4];
  int   mn [2]  = '{0, 0};
  int   stg [2] = '{2, 3};
  bit   enz [2] = '{1'b1, 1'b0};

  task automatic mstep(input int d);
    int last, lim;
    bit free0;
    last = stg[d] - 1;
    if (ready && mn[d] > 0 && mq[d][0].pos == last) begin
      for (int i = 0; i < mn[d] - 1; i++) mq[d][i] = mq[d][i+1];
      mn[d]--;
    end
    for (int i = 0; i < mn[d]; i++) begin
      lim = (i == 0) ? last : mq[d][i-1].pos - 1;
      mq[d][i].pos = (mq[d][i].pos + 1 < lim) ? mq[d][i].pos + 1 : lim;
    end
    free0 = (mn[d] == 0) || (mq[d][mn[d]-1].pos > 0);
    if (flush) begin
      mn[d] = 0;
    end else if (valid && free0) begin
      mq[d][mn[d]] = '{ref_imm(inst, sel, enz[d]), tag, 0};
      mn[d]++;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mn[0] = 0;
      mn[1] = 0;
    end else begin
      mstep(0);
      mstep(1);
    end
  end

  // Mid-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("a_count", 64'(bus_a.o_count), 64'(mn[0]));
      chk("a_ready", 64'(bus_a.o_ready), 64'((mn[0] < stg[0]) || ready));
      chk("a_valid", 64'(bus_a.o_valid), 64'(mn[0] > 0 && mq[0][0].pos == stg[0] - 1));
      if (mn[0] > 0 && mq[0][0].pos == stg[0] - 1) begin
        chk("a_imm", 64'(bus_a.o_imm), 64'(mq[0][0].imm[31:0]));
        chk("a_tag", 64'(bus_a.o_tag), 64'(mq[0][0].tag));
      end
      chk("b_count", 64'(bus_b.o_count), 64'(mn[1]));
      chk("b_ready", 64'(bus_b.o_ready), 64'((mn[1] < stg[1]) || ready));
      chk("b_valid", 64'(bus_b.o_valid), 64'(mn[1] > 0 && mq[1][0].pos == stg[1] - 1));
      if (mn[1] > 0 && mq[1][0].pos == stg[1] - 1) begin
        chk("b_imm", bus_b.o_imm, mq[1][0].imm);
        chk("b_tag", 64'(bus_b.o_tag), 64'(mq[1][0].tag));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  sel;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  int ia = 0;
  int ib = 0;

  task automatic observe();
    if (bus_a.o_valid) begin
      if (ia < NV) begin
        chk("tbl_a_imm", 64'(bus_a.o_imm), 64'(vecs[ia].exp_a[31:0]));
        chk("tbl_a_tag", 64'(bus_a.o_tag), 64'(ia));
      end
      ia++;
    end
    if (bus_b.o_valid) begin
      if (ib < NV) begin
        chk("tbl_b_imm", bus_b.o_imm, vecs[ib].exp_b);
        chk("tbl_b_tag", 64'(bus_b.o_tag), 64'(ib));
      end
      ib++;
    end
  endtask

  initial begin
    vecs[0] = '{32'h09000913, IMM_I, 64'd144, 64'd144};
    vecs[1] = '{32'hff312e23, IMM_S, 64'hffff_fffc, 64'hffff_ffff_ffff_fffc};
    vecs[2] = '{32'hff390ce3, IMM_B, 64'hffff_fff8, 64'hffff_ffff_ffff_fff8};
    vecs[3] = '{32'h00abca37, IMM_U, 64'h00ab_c000, 64'h00ab_c000};
    vecs[4] = '{32'hffdff06f, IMM_J, 64'hffff_fffc, 64'hffff_ffff_ffff_fffc};
    vecs[5] = '{32'h80000037, IMM_U, 64'h8000_0000, 64'hffff_ffff_8000_0000};
    vecs[6] = '{32'h300fd073, IMM_Z, 64'd31, 64'd0};
    vecs[7] = '{32'h300fd073, 3'd7, 64'd0, 64'd0};
    vecs[8] = '{32'hfff00093, IMM_I, 64'hffff_ffff, 64'hffff_ffff_ffff_ffff};
    vecs[9] = '{32'hfff00093, 3'd6, 64'd0, 64'd0};

    inst = '0; sel = '0; tag = '0; valid = 1'b0; flush = 1'b0; ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", 64'(bus_a.o_valid), 64'd0);
    chk("rst_a_imm", 64'(bus_a.o_imm), 64'd0);
    chk("rst_a_count", 64'(bus_a.o_count), 64'd0);
    chk("rst_b_count", 64'(bus_b.o_count), 64'd0);
    rst = 1'b0;
    ready = 1'b0;
    #1;
    chk("post_rst_a_ready", 64'(bus_a.o_ready), 64'd1);
    chk("post_rst_b_ready", 64'(bus_b.o_ready), 64'd1);
    ready = 1'b1;
    chk_on = 1'b1;
    tick();

    // Single addi through the 2-stage instance
    valid = 1'b1; inst = 32'h09000913; sel = IMM_I; tag = 5'd3;
    tick();
    valid = 1'b0;
    chk("r33_v_early", 64'(bus_a.o_valid), 64'd0);
    tick();
    chk("r33_v", 64'(bus_a.o_valid), 64'd1);
    chk("r33_imm", 64'(bus_a.o_imm), 64'd144);
    chk("r33_tag", 64'(bus_a.o_tag), 64'd3);
    tick();
    chk("r33_v_once", 64'(bus_a.o_valid), 64'd0);
    repeat (3) tick();

    // Vector table streamed back-to-back at full rate
    for (int i = 0; i < NV; i++) begin
      valid = 1'b1; inst = vecs[i].inst; sel = vecs[i].sel; tag = TW'(i);
      tick();
      observe();
    end
    valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      observe();
    end
    chk("tbl_a_n", 64'(ia), 64'(NV));
    chk("tbl_b_n", 64'(ib), 64'(NV));

    // Stall: three offers against a blocked 2-stage pipe, then drain in order
    ready = 1'b0;
    valid = 1'b1; inst = 32'hff312e23; sel = IMM_S; tag = 5'd1;
    chk("r34_ready0", 64'(bus_a.o_ready), 64'd1);
    tick();
    inst = 32'hff390ce3; sel = IMM_B; tag = 5'd2;
    tick();
    inst = 32'h00abca37; sel = IMM_U; tag = 5'd4;
    chk("r34_ready_full", 64'(bus_a.o_ready), 64'd0);
    chk("r34_count", 64'(bus_a.o_count), 64'd2);
    tick();
    chk("r34_hold_count", 64'(bus_a.o_count), 64'd2);
    chk("r34_hold_imm", 64'(bus_a.o_imm), 64'hffff_fffc);
    ready = 1'b1;
    #1;
    chk("r34_out0", 64'(bus_a.o_imm), 64'hffff_fffc);
    tick();
    valid = 1'b0;
    chk("r34_out1", 64'(bus_a.o_imm), 64'hffff_fff8);
    tick();
    chk("r34_out2_v", 64'(bus_a.o_valid), 64'd1);
    chk("r34_out2", 64'(bus_a.o_imm), 64'h00ab_c000);
    repeat (4) tick();
    chk("r34_empty", 64'(bus_a.o_count), 64'd0);

    // Full 3-stage pipe: accept+transfer keeps count, then flush with a live offer
    ready = 1'b0; valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst = $urandom; sel = IMM_I; tag = TW'(10 + i);
      tick();
    end
    chk("full_b_count", 64'(bus_b.o_count), 64'd3);
    chk("full_b_ready", 64'(bus_b.o_ready), 64'd0);
    ready = 1'b1; inst = 32'h00100093; tag = 5'd20;
    tick();
    chk("r30_b_count", 64'(bus_b.o_count), 64'd3);
    flush = 1'b1; inst = 32'h7ff00093; tag = 5'd31;
    #1;
    chk("r37_ready", 64'(bus_b.o_ready), 64'd1);
    tick();
    flush = 1'b0; valid = 1'b0;
    chk("r37_count", 64'(bus_b.o_count), 64'd0);
    chk("r37_valid", 64'(bus_b.o_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r37_no_ghost", 64'(bus_b.o_valid), 64'd0);
    end

    // Asynchronous reset between edges while output is valid
    valid = 1'b1; ready = 1'b1; inst = 32'h09000913; sel = IMM_I; tag = 5'd7;
    repeat (3) tick();
    chk("r38_pre_valid", 64'(bus_a.o_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("r38_valid", 64'(bus_a.o_valid), 64'd0);
    chk("r38_imm", 64'(bus_a.o_imm), 64'd0);
    chk("r38_count", 64'(bus_a.o_count), 64'd0);
    chk("r38_b_imm", bus_b.o_imm, 64'd0);
    valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("r32_ready", 64'(bus_a.o_ready), 64'd1);
    chk("r32_valid", 64'(bus_a.o_valid), 64'd0);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      inst  = $urandom;
      sel   = 3'($urandom_range(0, 7));
      tag   = TW'($urandom);
      valid = ($urandom % 4) != 0;
      ready = ($urandom % 3) != 0;
      flush = ($urandom % 20) == 0;
      tick();
    end
    valid = 1'b0; flush = 1'b0; ready = 1'b1;
    repeat (6) tick();
    chk("drain_a", 64'(bus_a.o_count), 64'd0);
    chk("drain_b", 64'(bus_b.o_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
